conv_tap_addr_gen: RTL and testbench

Parametrised convolution-window address generator that drives the picture-side read ports of up to N_UNITS MAC lanes. One start command streams one address per enabled lane for every kernel tap, covering a 2-D kernel with independent height/width, dilation, output stride and row pitch. A valid/ready handshake allows back-pressure from the memory arbiter, and lane-local bases are computed by compaction over the enabled-lane mask. It sits between the layer sequencer, which issues start and config, and the picture buffer read crossbar.

---
 rtl/conv_tap_addr_gen.sv | 161 ++++++++++++++++
 tb/tb_conv_tap_addr_gen.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/conv_tap_addr_gen.sv
// Convolution-window tap address generator: one address per enabled lane for every
// kernel tap, row-major, with valid/ready back-pressure toward the read crossbar.

module conv_tap_lane #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              en_in,
  input  logic [ADDR_W-1:0] base_in,
  input  logic [ADDR_W-1:0] off,
  output logic [ADDR_W-1:0] addr
);
  logic              en_q;
  logic [ADDR_W-1:0] base_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q   <= 1'b0;
      base_q <= '0;
      addr   <= '0;
    end else if (load) begin
      en_q   <= en_in;
      base_q <= base_in;
      addr   <= en_in ? base_in : '0;
    end else if (step) begin
      addr   <= en_q ? base_q + off : '0;
    end
  end
endmodule

module conv_tap_addr_gen #(
  parameter int N_UNITS = 16,
  parameter int ADDR_W  = 32,
  parameter int DIM_W   = 16,
  parameter int K_W     = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            abort,
  input  logic [ADDR_W-1:0]               start_addr,
  input  logic [K_W-1:0]                  kernel_h,
  input  logic [K_W-1:0]                  kernel_w,
  input  logic [K_W-1:0]                  dilation,
  input  logic [DIM_W-1:0]                stride,
  input  logic [DIM_W-1:0]                row_pitch,
  input  logic [N_UNITS-1:0]              unit_en,
  output logic                            busy,
  output logic                            done,
  output logic                            addr_valid,
  input  logic                            addr_ready,
  output logic [N_UNITS-1:0][ADDR_W-1:0]  addr_out,
  output logic [K_W-1:0]                  tap_row,
  output logic [K_W-1:0]                  tap_col,
  output logic                            tap_last
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t                        state, state_nxt;
  logic [K_W-1:0]                kh_q, kw_q;
  logic [ADDR_W-1:0]             row_step, col_step;
  logic [ADDR_W-1:0]             row_off, col_off, row_off_n, col_off_n, off;
  logic [K_W-1:0]                r_n, c_n;
  logic                          wrap, load, step;
  logic [N_UNITS-1:0][ADDR_W-1:0] base_in;

  // Lane bases by prefix-summing stride over the enabled mask (rank * stride without a multiplier).
  always_comb begin
    logic [ADDR_W-1:0] acc;
    acc     = start_addr;
    base_in = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      base_in[i] = acc;
      if (unit_en[i]) acc = acc + ADDR_W'(stride);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!abort && start)
                 state_nxt = (kernel_h == '0 || kernel_w == '0) ? FIN : RUN;
      RUN:     if (abort)                      state_nxt = IDLE;
               else if (addr_ready && tap_last) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign load = (state == IDLE) && start && !abort;
  assign step = (state == RUN) && addr_ready && !abort && !tap_last;

  assign wrap      = (tap_col == kw_q - K_W'(1));
  assign c_n       = wrap ? '0 : tap_col + K_W'(1);
  assign r_n       = wrap ? tap_row + K_W'(1) : tap_row;
  assign col_off_n = wrap ? '0 : col_off + col_step;
  assign row_off_n = wrap ? row_off + row_step : row_off;
  assign off       = row_off_n + col_off_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      addr_valid <= 1'b0;
      tap_row    <= '0;
      tap_col    <= '0;
      tap_last   <= 1'b0;
      kh_q       <= '0;
      kw_q       <= '0;
      row_step   <= '0;
      col_step   <= '0;
      row_off    <= '0;
      col_off    <= '0;
    end else begin
      busy       <= (state_nxt == RUN);
      addr_valid <= (state_nxt == RUN);
      done       <= (state_nxt == FIN);
      if (load) begin
        kh_q     <= kernel_h;
        kw_q     <= kernel_w;
        col_step <= ADDR_W'(dilation);
        // One product per window; taps then advance by addition only.
        row_step <= ADDR_W'(dilation) * ADDR_W'(row_pitch);
        row_off  <= '0;
        col_off  <= '0;
        tap_row  <= '0;
        tap_col  <= '0;
        tap_last <= (kernel_h == K_W'(1)) && (kernel_w == K_W'(1));
      end else if (step) begin
        row_off  <= row_off_n;
        col_off  <= col_off_n;
        tap_row  <= r_n;
        tap_col  <= c_n;
        tap_last <= (r_n == kh_q - K_W'(1)) && (c_n == kw_q - K_W'(1));
      end else if (state_nxt != RUN) begin
        tap_last <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < N_UNITS; i++) begin : g_lane
    conv_tap_lane #(.ADDR_W(ADDR_W)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .step    (step),
      .en_in   (unit_en[i]),
      .base_in (base_in[i]),
      .off     (off),
      .addr    (addr_out[i])
    );
  end
endmodule

// File: tb/tb_conv_tap_addr_gen.sv
// Bench for conv_tap_addr_gen: directed and randomized windows against an arithmetic
// reference of the tap-address formula, with back-pressure, abort and reset disturbances.

module tb_conv_tap_addr_gen;
  localparam int N  = 16;
  localparam int AW = 32;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start, abort, addr_ready;
  logic [AW-1:0]          start_addr;
  logic [7:0]             kernel_h, kernel_w, dilation;
  logic [15:0]            stride, row_pitch;
  logic [N-1:0]           unit_en;
  logic                   busy, done, addr_valid, tap_last;
  logic [N-1:0][AW-1:0]   addr_out;
  logic [7:0]             tap_row, tap_col;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_sa, m_st, m_dil, m_pitch;
  logic [N-1:0] m_en;
  logic [31:0] cap;

  conv_tap_addr_gen dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .start_addr(start_addr),
    .kernel_h(kernel_h), .kernel_w(kernel_w), .dilation(dilation), .stride(stride),
    .row_pitch(row_pitch), .unit_en(unit_en), .busy(busy), .done(done),
    .addr_valid(addr_valid), .addr_ready(addr_ready), .addr_out(addr_out),
    .tap_row(tap_row), .tap_col(tap_col), .tap_last(tap_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: address = start + rank*stride + r*dil*pitch + c*dil, mod 2^32; 0 for disabled lanes.
  function automatic logic [N*AW-1:0] model_addr(input int r, input int c);
    logic [N-1:0][AW-1:0] v;
    logic [31:0] rank;
    rank = 0;
    for (int i = 0; i < N; i++) begin
      if (m_en[i]) begin
        v[i] = m_sa + rank * m_st + 32'(r) * m_dil * m_pitch + 32'(c) * m_dil;
        rank++;
      end else v[i] = '0;
    end
    return v;
  endfunction

  task automatic scramble_cfg();
    kernel_h   = 8'($urandom);
    kernel_w   = 8'($urandom);
    dilation   = 8'($urandom);
    stride     = 16'($urandom);
    row_pitch  = 16'($urandom);
    start_addr = $urandom;
    unit_en    = 16'($urandom);
  endtask

  task automatic run_win(input int kh, input int kw, input logic [7:0] dil, input logic [15:0] st,
                         input logic [15:0] pitch, input logic [31:0] sa, input logic [N-1:0] en,
                         input bit bp, input int abort_at, input bit poke,
                         input int cap_beat, input int cap_lane);
    int total, beats, r, c;
    bit fin, ab;
    total = kh * kw; beats = 0; fin = 0; cap = '0;
    m_sa = sa; m_st = 32'(st); m_dil = 32'(dil); m_pitch = 32'(pitch); m_en = en;
    kernel_h = 8'(kh); kernel_w = 8'(kw); dilation = dil; stride = st;
    row_pitch = pitch; start_addr = sa; unit_en = en; addr_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      scramble_cfg();
      start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      if (beats == total) begin
        check("done_pulse", done, 1);
        check("valid_at_done", addr_valid, 0);
        fin = 1;
      end else begin
        r = beats / kw; c = beats % kw;
        check("valid", addr_valid, 1);
        check("busy", busy, 1);
        check("done_early", done, 0);
        check("tap_row", tap_row, r);
        check("tap_col", tap_col, c);
        check("tap_last", tap_last, (beats == total - 1));
        check("addr_out", addr_out, model_addr(r, c));
        if (beats == cap_beat) cap = addr_out[cap_lane];
        addr_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        ab = (beats == abort_at);
        if (ab) begin abort = 1'b1; addr_ready = 1'b1; end
        @(posedge clk); #1;
        if (ab) begin
          abort = 1'b0; start = 1'b0;
          check("abort_valid", addr_valid, 0);
          check("abort_busy", busy, 0);
          check("abort_done", done, 0);
          @(posedge clk); #1;
          check("abort_no_done", done, 0);
          fin = 1;
        end else if (addr_ready) beats++;
      end
    end
    if (!fin) check("window_timeout", 0, 1);
    start = 1'b0; addr_ready = 1'b1;
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; addr_ready = 1'b1;
    start_addr = '0; kernel_h = '0; kernel_w = '0; dilation = '0;
    stride = '0; row_pitch = '0; unit_en = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", addr_valid, 0);
    check("rst_last", tap_last, 0);
    check("rst_taps", {tap_row, tap_col}, 0);
    check("rst_addr", addr_out, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic 3x3, all lanes
    run_win(3, 3, 8'd1, 16'd1, 16'd64, 32'h1000, 16'hFFFF, 0, -1, 0, 5, 5);
    check("lane5_tap12", cap, 32'h1047);

    // Sparse mask
    run_win(2, 2, 8'd2, 16'd4, 16'd100, 32'h0, 16'h00A5, 0, -1, 0, 3, 7);
    check("lane7_tap11", cap, 32'd214);

    // Back-pressure with the basic config
    run_win(3, 3, 8'd1, 16'd1, 16'd64, 32'h1000, 16'hFFFF, 1, -1, 0, 5, 5);
    check("bp_lane5_tap12", cap, 32'h1047);

    // Zero-width kernel and 1x1 kernel
    run_win(4, 0, 8'd1, 16'd1, 16'd64, 32'h2000, 16'hFFFF, 0, -1, 0, -1, 0);
    run_win(1, 1, 8'd3, 16'd8, 16'd32, 32'h3000, 16'h0F0F, 0, -1, 0, -1, 0);

    // Address wrap-around
    run_win(2, 2, 8'd1, 16'd1, 16'd16, 32'hFFFF_FFFE, 16'hFFFF, 0, -1, 0, 0, 2);
    check("wrap_lane2", cap, 32'h0);

    // Start pokes during RUN/FIN, abort after 4 beats, empty mask
    run_win(4, 3, 8'd2, 16'd3, 16'd50, 32'h4000, 16'h5A5A, 1, -1, 1, -1, 0);
    run_win(3, 3, 8'd1, 16'd2, 16'd64, 32'h5000, 16'hFFFF, 0, 4, 0, -1, 0);
    run_win(2, 3, 8'd1, 16'd2, 16'd64, 32'h6000, 16'h0000, 0, -1, 0, -1, 0);

    // Asynchronous reset mid-window
    kernel_h = 8'd3; kernel_w = 8'd3; dilation = 8'd1; stride = 16'd1;
    row_pitch = 16'd64; start_addr = 32'h7000; unit_en = 16'hFFFF; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", addr_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_taps", {tap_last, tap_row, tap_col}, 0);
    check("arst_addr", addr_out, '0);
    @(posedge clk); #1; rst = 1'b0;
    check("arst_no_done", done, 0);
    run_win(3, 3, 8'd1, 16'd1, 16'd64, 32'h1000, 16'hFFFF, 0, -1, 0, 5, 5);
    check("after_rst_lane5", cap, 32'h1047);

    // Randomized windows
    for (int k = 0; k < 8; k++)
      run_win($urandom_range(1, 5), $urandom_range(1, 5), 8'($urandom_range(0, 7)),
              16'($urandom), 16'($urandom), $urandom, 16'($urandom),
              1'($urandom_range(0, 1)), -1, 1'($urandom_range(0, 1)), -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
